steer_quad_gen: RTL and testbench
=================================

// Module: steer_quad_gen
// PURPOSE
//  Converts digital left/right steering controls (keyboard/joystick) into the
//  2-bit quadrature pair expected by the Sprint 2 core Steer_xA/Steer_xB inputs.
//  One instance per player, upstream of the sprint2 core. Step rate ramps up
//  while a direction is held (wheel "spin-up"), saturating at a minimum period.
// PARAMETERS
//  CLKDIV_MAX  22500  step period (clocks) for the first interval after a press
//  CLKDIV_MIN  5625   minimum step period (saturation); 1 <= MIN <= MAX
//  ACCEL_STEP  1125   period decrement applied at each step while held
//  CNT_W       16     period/counter width; CLKDIV_MAX < 2**CNT_W
// PORTS
//  CLK     in   1  core clock (6 MHz video clock domain)
//  reset   in   1  asynchronous, active-high reset
//  left    in   1  steer left request, async to CLK, active high
//  right   in   1  steer right request, async to CLK, active high
//  steer   out  2  quadrature {A,B}; steer[1]->Steer_A_I, steer[0]->Steer_B_I
//  moving  out  1  1 while in RUN state
//  dir     out  1  current direction: 1 = right, 0 = left (valid while moving)
// BEHAVIOUR
//  - One clock, one asynchronous active-high reset. Reset values: steer=00,
//    moving=0, dir=0, state=IDLE, per=CLKDIV_MAX, cnt=0, sync flops=0.
//  - left/right pass through 2-flop synchronisers (lS, rS). Request decode:
//    R = rS&~lS, L = lS&~rS; both or neither = no request.
//  - Phase sequence (right = forward): 00 -> 01 -> 11 -> 10 -> 00 (Gray,
//    exactly one bit changes per step); left walks it in reverse. Wraps freely.
//  - States: IDLE, RUN.
//    IDLE: on R or L -> RUN; same edge: steer steps once in that direction,
//      dir <= request, per <= CLKDIV_MAX, cnt <= CLKDIV_MAX-1.
//    RUN, request same as dir: if cnt==0 -> step, pn = max(per-ACCEL_STEP,
//      CLKDIV_MIN) (subtract done at CNT_W+1 bits, no underflow), per <= pn,
//      cnt <= pn-1; else cnt <= cnt-1. Successive step spacing is therefore
//      MAX, MAX-ACCEL, ... , MIN, MIN, ...
//    RUN, request opposite to dir: treated as a fresh press: immediate step
//      in new direction, dir flips, per <= CLKDIV_MAX, cnt <= CLKDIV_MAX-1.
//    RUN, no request (release or both pressed): -> IDLE, per <= CLKDIV_MAX,
//      cnt <= 0; steer holds its last phase (no step on release).
//  - moving = (state==RUN), registered with state.
//  - Latency: raw input edge to first steer change = 3 CLK edges (2 sync + 1).
//  - All outputs registered; steer never glitches or changes 2 bits at once.
//  - reset asserted mid-RUN: outputs go to reset values immediately
//    (asynchronously); after release, block idles until a new request.
// TESTING (bench params CLKDIV_MAX=20, CLKDIV_MIN=8, ACCEL_STEP=4, CNT_W=8)
//  1 right held from t0 -> steer 01 at edge 3, 11 at +20, 10 at +16, 00 at
//    +12, 01 at +8, then every 8 clocks; moving=1, dir=1 throughout.
//  2 left held from reset -> steer 10, 11, 01, 00 with spacing 20,16,12;
//    dir=0; every transition changes exactly one bit.
//  3 right held to saturation, then release -> steer frozen at last phase,
//    moving=0 three edges after release; re-press -> next step 20 after first.
//  4 right held past 2 steps, switch to left with no gap -> reverse step on
//    3rd edge after switch, next reverse step exactly 20 clocks later.
//  5 left and right both held from idle for 200 clocks -> steer stays 00,
//    moving=0; drop left -> steer 01 three edges later.
//  6 reset pulsed (async, between edges) mid-RUN at phase 11 -> steer=00,
//    moving=0 before next edge; no steps while input held low after reset.

Source files
------------

// File: rtl/steer_quad_gen.sv
// Steering quadrature generator: left/right requests become a Gray-coded
// {A,B} step stream whose rate ramps up while a direction is held.
module steer_quad_gen #(
  parameter int CLKDIV_MAX = 22500,
  parameter int CLKDIV_MIN = 5625,
  parameter int ACCEL_STEP = 1125,
  parameter int CNT_W      = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  output logic [1:0] steer,
  output logic       moving,
  output logic       dir
);

  localparam logic [CNT_W-1:0] PER_MAX = CNT_W'(CLKDIV_MAX);
  localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(CLKDIV_MIN);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLKDIV_MAX - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W:0]   ACC_X   = (CNT_W+1)'(ACCEL_STEP);
  localparam logic [CNT_W:0]   MIN_X   = (CNT_W+1)'(CLKDIV_MIN);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic             l_s1, l_s2, r_s1, r_s2;
  logic             req_r, req_l, req_any;
  logic [CNT_W-1:0] per, per_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] pn;
  logic [CNT_W:0]   sub;
  logic [1:0]       steer_nx, fwd, rev, stepped;
  logic             dir_nx;

  assign req_r   = r_s2 & ~l_s2;
  assign req_l   = l_s2 & ~r_s2;
  assign req_any = req_r | req_l;

  // Gray walk: 00->01->11->10 forward, reverse for left
  assign fwd     = {steer[0], ~steer[1]};
  assign rev     = {~steer[0], steer[1]};
  assign stepped = req_r ? fwd : rev;

  // Extra bit catches underflow before clamping to the minimum period
  assign sub = {1'b0, per} - ACC_X;
  assign pn  = (sub[CNT_W] || sub < MIN_X) ? PER_MIN : sub[CNT_W-1:0];

  always_comb begin
    state_nx = state;
    per_nx   = per;
    cnt_nx   = cnt;
    steer_nx = steer;
    dir_nx   = dir;
    if (!req_any) begin
      state_nx = IDLE;
      per_nx   = PER_MAX;
      cnt_nx   = '0;
    end else if (state == IDLE || req_r != dir) begin
      state_nx = RUN;
      steer_nx = stepped;
      dir_nx   = req_r;
      per_nx   = PER_MAX;
      cnt_nx   = CNT_TOP;
    end else if (cnt == '0) begin
      steer_nx = stepped;
      per_nx   = pn;
      cnt_nx   = pn - ONE;
    end else begin
      cnt_nx   = cnt - ONE;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      l_s1   <= 1'b0;
      l_s2   <= 1'b0;
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      state  <= IDLE;
      per    <= PER_MAX;
      cnt    <= '0;
      steer  <= 2'b00;
      dir    <= 1'b0;
      moving <= 1'b0;
    end else begin
      l_s1   <= left;
      l_s2   <= l_s1;
      r_s1   <= right;
      r_s2   <= r_s1;
      state  <= state_nx;
      per    <= per_nx;
      cnt    <= cnt_nx;
      steer  <= steer_nx;
      dir    <= dir_nx;
      moving <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_steer_quad_gen.sv
// Bench for steer_quad_gen: scripted and random steering against an
// event-time reference model, checked by a scoreboard monitor.
module tb_steer_quad_gen;

  localparam int MAX = 20;
  localparam int MIN = 8;
  localparam int ACC = 4;
  localparam int W   = 8;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic [1:0] steer;
  logic       moving;
  logic       dir;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] steer;
    logic       moving;
    logic       dir;
  } obs_t;

  obs_t       q[$];
  logic [1:0] hist[$];
  logic [1:0] code [4];

  int edge_n;
  bit m_mov;
  bit m_dir;
  int m_ph;
  int m_next;
  int m_int;

  steer_quad_gen #(
    .CLKDIV_MAX(MAX),
    .CLKDIV_MIN(MIN),
    .ACCEL_STEP(ACC),
    .CNT_W(W)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .left(left),
    .right(right),
    .steer(steer),
    .moving(moving),
    .dir(dir)
  );

  always #5 CLK = ~CLK;

  function automatic void model_clear();
    hist.delete();
    hist.push_back(2'b00);
    hist.push_back(2'b00);
    m_mov = 0;
    m_dir = 0;
    m_ph = 0;
    m_next = 0;
    m_int = MAX;
  endfunction

  // Decision at edge n uses the request present two edges earlier
  task automatic model_edge();
    logic [1:0] h;
    int rq;
    hist.push_back({left, right});
    h = hist.pop_front();
    edge_n++;
    rq = (h == 2'b01) ? 1 : (h == 2'b10) ? 2 : 0;
    if (rq == 0) begin
      m_mov = 0;
    end else if (!m_mov || m_dir != (rq == 1)) begin
      m_mov = 1;
      m_dir = (rq == 1);
      m_ph = (m_ph + (m_dir ? 1 : 3)) % 4;
      m_int = MAX;
      m_next = edge_n + MAX;
    end else if (edge_n == m_next) begin
      m_ph = (m_ph + (m_dir ? 1 : 3)) % 4;
      m_int = (m_int - ACC < MIN) ? MIN : m_int - ACC;
      m_next = edge_n + m_int;
    end
    q.push_back({code[m_ph], m_mov, m_dir});
  endtask

  task automatic run(input logic l, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_edge();
      #1;
      left = l;
      right = r;
    end
  endtask

  task automatic mid_reset();
    obs_t got;
    @(negedge CLK);
    #2;
    reset = 1'b1;
    left = 1'b0;
    right = 1'b0;
    #1;
    got = {steer, moving, dir};
    checks++;
    if (got != 4'b0000) begin
      errors++;
      $display("FAIL async_reset got=%b want=0000 t=%0t", got, $time);
    end
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    obs_t got;
    while (1) begin
      @(negedge CLK);
      if (q.size() > 0) begin
        obs_t exp_v;
        exp_v = q.pop_front();
        got = {steer, moving, dir};
        checks++;
        if (got != exp_v) begin
          errors++;
          $display("FAIL edge%0d steer/moving/dir got=%b want=%b",
                   edge_n, got, exp_v);
        end
      end
    end
  end

  initial begin
    obs_t got;
    code[0] = 2'b00;
    code[1] = 2'b01;
    code[2] = 2'b11;
    code[3] = 2'b10;
    edge_n = 0;
    model_clear();
    #12;
    got = {steer, moving, dir};
    checks++;
    if (got != 4'b0000) begin
      errors++;
      $display("FAIL reset_state got=%b want=0000", got);
    end
    @(negedge CLK);
    #2;
    reset = 1'b0;
    right = 1'b1;
    run(0, 1, 100);
    run(0, 0, 10);
    run(1, 0, 70);
    run(0, 0, 5);
    run(0, 1, 80);
    run(0, 0, 10);
    run(0, 1, 30);
    run(0, 1, 30);
    run(1, 0, 40);
    run(0, 0, 5);
    run(1, 1, 200);
    run(0, 1, 20);
    run(0, 0, 5);
    mid_reset();
    run(0, 1, 30);
    mid_reset();
    run(0, 0, 20);
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 9) == 0)
        mid_reset();
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(1, 60));
    end
    run(0, 0, 5);
    @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
